// File: rtl/seq_detect_param.sv
// Serial pattern detector with a run-time loadable pattern of 1..PAT_W bits.
// A history shift register plus a fill count of valid bits are compared
// against the latched pattern on every consumed bit. A match produces a
// registered one-cycle pulse and bumps a saturating match counter.
// Overlapping or non-overlapping detection is selected at config load time.
module seq_detect_param #(
    parameter int PAT_W = 8,
    parameter int CNT_W = 8,
    parameter int LEN_W = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in,
    input  logic             in_valid,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] pat,
    input  logic [LEN_W-1:0] pat_len,
    input  logic             overlap_en,
    input  logic             cnt_clr,
    output logic             out,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cfg_err
);

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [PAT_W-1:0] cfg_pat_q, cfg_pat_d;
    logic [LEN_W-1:0] cfg_len_q, cfg_len_d;
    logic             cfg_ovl_q, cfg_ovl_d;
    logic             cfg_err_q, cfg_err_d;
    logic [PAT_W-1:0] hist_q, hist_d;
    logic [LEN_W-1:0] fill_q, fill_d;
    logic             out_q, out_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [PAT_W-1:0] len_mask;
    logic [PAT_W-1:0] hist_shift;
    logic [LEN_W-1:0] fill_inc;
    logic             match;

    // Mask selecting the low cfg_len bits; pattern bits above it are don't-care.
    generate
        for (genvar gi = 0; gi < PAT_W; gi++) begin : g_mask
            assign len_mask[gi] = (LEN_W'(gi) < cfg_len_q);
        end
    endgenerate

    // History and fill as they would look after consuming the current bit.
    always_comb begin
        hist_shift = {hist_q[PAT_W-2:0], in};
        fill_inc   = (fill_q >= LEN_MAX) ? LEN_MAX : fill_q + LEN_W'(1);
        match      = in_valid && !cfg_err_q && (fill_inc >= cfg_len_q) &&
                     (((hist_shift ^ cfg_pat_q) & len_mask) == '0);
    end

    // Next-state: config load discards the bit and empties the history;
    // otherwise a consumed bit shifts in and may complete a match.
    always_comb begin
        cfg_pat_d = cfg_pat_q;
        cfg_len_d = cfg_len_q;
        cfg_ovl_d = cfg_ovl_q;
        cfg_err_d = cfg_err_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        out_d     = 1'b0;
        cnt_d     = cnt_q;
        if (cfg_load) begin
            cfg_pat_d = pat;
            cfg_len_d = pat_len;
            cfg_ovl_d = overlap_en;
            cfg_err_d = (pat_len == '0) || (pat_len > LEN_MAX);
            hist_d    = '0;
            fill_d    = '0;
        end else if (in_valid) begin
            hist_d = hist_shift;
            // Non-overlapping mode restarts the fill so no bit is reused.
            fill_d = (match && !cfg_ovl_q) ? '0 : fill_inc;
            out_d  = match;
            if (match && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        // Clearing the counter wins over a coincident match.
        if (cnt_clr) begin
            cnt_d = '0;
        end
    end

    // State registers with synchronous reset to the default (legal) config.
    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_pat_q <= '0;
            cfg_len_q <= LEN_MAX;
            cfg_ovl_q <= 1'b1;
            cfg_err_q <= 1'b0;
            hist_q    <= '0;
            fill_q    <= '0;
            out_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            cfg_pat_q <= cfg_pat_d;
            cfg_len_q <= cfg_len_d;
            cfg_ovl_q <= cfg_ovl_d;
            cfg_err_q <= cfg_err_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            out_q     <= out_d;
            cnt_q     <= cnt_d;
        end
    end

    assign out       = out_q;
    assign match_cnt = cnt_q;
    assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: two instances (8-bit and 2-bit counters) share
// stimulus; a queue-based reference model is checked every cycle, and directed
// streams pin the model with hand-computed expectations.
module tb_seq_detect_param;

    localparam int PAT_W = 8;
    localparam int LEN_W = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             din = 1'b0;
    logic             in_valid = 1'b0;
    logic             cfg_load = 1'b0;
    logic [PAT_W-1:0] pat = '0;
    logic [LEN_W-1:0] pat_len = '0;
    logic             overlap_en = 1'b0;
    logic             cnt_clr = 1'b0;
    logic             out8, out2, err8, err2;
    logic [7:0]       cnt8;
    logic [1:0]       cnt2;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    seq_detect_param #(.PAT_W(PAT_W), .CNT_W(8)) u8 (
        .clk(clk), .reset(reset), .in(din), .in_valid(in_valid),
        .cfg_load(cfg_load), .pat(pat), .pat_len(pat_len),
        .overlap_en(overlap_en), .cnt_clr(cnt_clr),
        .out(out8), .match_cnt(cnt8), .cfg_err(err8)
    );

    seq_detect_param #(.PAT_W(PAT_W), .CNT_W(2)) u2 (
        .clk(clk), .reset(reset), .in(din), .in_valid(in_valid),
        .cfg_load(cfg_load), .pat(pat), .pat_len(pat_len),
        .overlap_en(overlap_en), .cnt_clr(cnt_clr),
        .out(out2), .match_cnt(cnt2), .cfg_err(err2)
    );

    // Reference model: a queue holds the bits that may still take part in a
    // match (oldest first); a match compares its tail against the pattern.
    bit       q[$];
    int       m_len = PAT_W;
    bit [7:0] m_pat = '0;
    bit       m_ovl = 1'b1;
    bit       m_err = 1'b0;
    bit       m_out = 1'b0;
    int       m_cnt8 = 0;
    int       m_cnt2 = 0;

    always @(posedge clk) begin
        bit hit;
        hit = 1'b0;
        if (reset) begin
            q.delete();
            m_pat = '0; m_len = PAT_W; m_ovl = 1'b1; m_err = 1'b0;
            m_out = 1'b0; m_cnt8 = 0; m_cnt2 = 0;
        end else if (cfg_load) begin
            m_pat = pat; m_len = int'(pat_len); m_ovl = overlap_en;
            m_err = (m_len == 0) || (m_len > PAT_W);
            q.delete();
            m_out = 1'b0;
            if (cnt_clr) begin m_cnt8 = 0; m_cnt2 = 0; end
        end else begin
            if (in_valid) begin
                q.push_back(din);
                if (q.size() > PAT_W) void'(q.pop_front());
                if (!m_err && q.size() >= m_len) begin
                    hit = 1'b1;
                    for (int k = 0; k < m_len; k++)
                        if (q[q.size() - m_len + k] != m_pat[m_len - 1 - k]) hit = 1'b0;
                end
                if (hit && !m_ovl) q.delete();
            end
            m_out = hit;
            if (cnt_clr) begin
                m_cnt8 = 0; m_cnt2 = 0;
            end else if (hit) begin
                m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
                m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            tests++;
            if (out8 !== m_out || out2 !== m_out) begin
                fails++;
                $display("FAIL out @%0t: got %b/%b expected %b", $time, out8, out2, m_out);
            end
            tests++;
            if (cnt8 !== 8'(m_cnt8) || cnt2 !== 2'(m_cnt2)) begin
                fails++;
                $display("FAIL match_cnt @%0t: got %0d/%0d expected %0d/%0d",
                         $time, cnt8, cnt2, m_cnt8, m_cnt2);
            end
            tests++;
            if (err8 !== m_err || err2 !== m_err) begin
                fails++;
                $display("FAIL cfg_err @%0t: got %b/%b expected %b", $time, err8, err2, m_err);
            end
        end
    end

    task automatic lit(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Apply inputs for one clock; returns at negedge+1 with outputs settled.
    task automatic drive(input logic v, input logic b, input logic ld,
                         input logic clr, input logic rst);
        in_valid = v; din = b; cfg_load = ld; cnt_clr = clr; reset = rst;
        @(negedge clk);
        #1;
    endtask

    task automatic load(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] l, input logic o);
        pat = p; pat_len = l; overlap_en = o;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic clr();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    // Directed stream; vmask/bits/exp are read MSB-first over n cycles.
    task automatic stream(input string name, input int n, input logic [31:0] vmask,
                          input logic [31:0] bits, input logic [31:0] exp);
        for (int i = 0; i < n; i++) begin
            drive(vmask[n-1-i], bits[n-1-i], 1'b0, 1'b0, 1'b0);
            $display("[TB] %s step %0d: v=%b in=%b out=%b cnt=%0d",
                     name, i, vmask[n-1-i], bits[n-1-i], out8, cnt8);
            lit(name, int'(out8), int'(exp[n-1-i]));
        end
    endtask

    initial begin
        @(negedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);   // reset overrides load and clear
        chk_en = 1'b1;
        lit("reset_out", int'(out8), 0);
        lit("reset_cnt", int'(cnt8), 0);
        lit("reset_err", int'(err8), 0);

        // Overlapping 0110 in 0110110: pulses after bits 4 and 7
        load(8'b0110, 4'd4, 1'b1);
        stream("ovl", 7, 32'h7F, 32'b0110110, 32'b0001001);
        lit("ovl_cnt", int'(cnt8), 2);

        // Non-overlapping: single pulse
        load(8'b0110, 4'd4, 1'b0);
        clr();
        stream("novl", 7, 32'h7F, 32'b0110110, 32'b0001000);
        lit("novl_cnt", int'(cnt8), 1);

        // Gap in in_valid holds history
        load(8'b0110, 4'd4, 1'b1);
        clr();
        stream("gap", 7, 32'b1100011, 32'b0100010, 32'b0000001);
        lit("gap_cnt", int'(cnt8), 1);

        // Illegal lengths: 0 and PAT_W+1
        clr();
        for (int t = 0; t < 2; t++) begin
            load(8'hFF, (t == 0) ? 4'd0 : 4'(PAT_W + 1), 1'b1);
            lit("illegal_err", int'(err8), 1);
            for (int i = 0; i < 20; i++) begin
                drive(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
                lit("illegal_out", int'(out8), 0);
            end
            lit("illegal_cnt", int'(cnt8), 0);
        end

        // Saturation of a 2-bit counter, then clear coinciding with a match
        load(8'b1, 4'd1, 1'b1);
        lit("len1_err", int'(err8), 0);
        clr();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            lit("sat_cnt2", int'(cnt2), (i < 3) ? i + 1 : 3);
        end
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        lit("clr_win_out", int'(out8), 1);
        lit("clr_win_cnt2", int'(cnt2), 0);

        // Reset mid-pattern, then load coinciding with a valid bit
        load(8'b0110, 4'd4, 1'b1);
        stream("pre_rst", 3, 32'b111, 32'b011, 32'b000);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        lit("post_rst_out", int'(out8), 0);
        pat = 8'b0110; pat_len = 4'd4; overlap_en = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        stream("ld_vs_bit", 6, 32'h3F, 32'b110110, 32'b000001);

        // Randomized traffic checked by the model
        for (int r = 0; r < 12; r++) begin
            int l;
            l = ($urandom_range(0, 9) == 0) ? ((r % 2 == 0) ? 0 : PAT_W + 1)
                                           : $urandom_range(1, 5);
            load(8'($urandom), 4'(l), 1'($urandom_range(0, 1)));
            for (int i = 0; i < 250; i++) begin
                drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 150) == 0), 1'($urandom_range(0, 40) == 0),
                      1'($urandom_range(0, 300) == 0));
            end
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 The block SHALL have parameter PAT_W, default 8, meaning the maximum pattern length in bits (legal 2..32).
REQ-002 The block SHALL have parameter CNT_W, default 8, meaning the match counter width.
REQ-003 The block SHALL have parameter LEN_W, default $clog2(PAT_W+1), meaning the pat_len width.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 The block SHALL have port in, input, 1, the serial data bit.
REQ-007 The block SHALL have port in_valid, input, 1, qualifying in; a bit is consumed only when in_valid=1.
REQ-008 The block SHALL have port cfg_load, input, 1, a one-cycle strobe that latches pat, pat_len and overlap_en.
REQ-009 The block SHALL have port pat, input, PAT_W, the pattern; pat[pat_len-1] is the first (oldest) bit expected and pat[0] the last.
REQ-010 The block SHALL have port pat_len, input, LEN_W, the active pattern length.
REQ-011 The block SHALL have port overlap_en, input, 1, where 1 = overlapping detection and 0 = non-overlapping.
REQ-012 The block SHALL have port cnt_clr, input, 1, which clears match_cnt.
REQ-013 The block SHALL have port out, output, 1, a registered one-cycle match pulse.
REQ-014 The block SHALL have port match_cnt, output, CNT_W, a saturating count of matches.
REQ-015 The block SHALL have port cfg_err, output, 1, flagging an illegal latched pat_len.

Function
REQ-016 The block SHALL hold latched config registers cfg_pat, cfg_len and cfg_ovl, updated only on cfg_load.
REQ-017 The block SHALL hold a PAT_W-bit history shift register hist; on a consumed bit, hist <= {hist[PAT_W-2:0], in}, so the newest bit is at hist[0].
REQ-018 The block SHALL hold a fill counter (0..PAT_W, saturating at PAT_W) that increments on each consumed bit and counts the valid history bits.
REQ-019 A match SHALL occur on a consumed bit when the post-shift fill >= cfg_len and the post-shift hist[cfg_len-1:0] == cfg_pat[cfg_len-1:0].
REQ-020 On a match, out SHALL be 1 in the cycle after the completing bit is sampled (Moore-registered; latency 1 clk), and 0 in every other cycle.
REQ-021 With cfg_ovl=1 the history and fill SHALL be retained after a match, so suffix bits may begin the next match.
REQ-022 With cfg_ovl=0 the fill SHALL be cleared to 0 on a match, so no bit counts toward two matches.
REQ-023 When in_valid=0, hist and fill SHALL hold their values and out SHALL be 0 in the following cycle.
REQ-024 Illegal cfg_len (0 or > PAT_W) SHALL set cfg_err=1 and suppress all matches; cfg_err SHALL otherwise be 0.
REQ-025 A cfg_load SHALL clear hist and fill and force out=0 next cycle; match_cnt SHALL be unaffected.
REQ-026 If cfg_load and in_valid coincide, cfg_load SHALL take priority and the bit SHALL be discarded.
REQ-027 On each match, match_cnt SHALL increment by 1 and saturate at 2^CNT_W-1.
REQ-028 If cnt_clr and a match coincide, match_cnt SHALL become 0 (clear wins).
REQ-029 cfg_pat bits at index >= cfg_len SHALL be ignored.

Reset
REQ-030 On reset=1 at a clk edge: hist=0, fill=0, out=0, match_cnt=0, cfg_pat=0, cfg_len=PAT_W, cfg_ovl=1, cfg_err=0.
REQ-031 reset SHALL override cfg_load, cnt_clr and in_valid in the same cycle.
REQ-032 A reset asserted mid-pattern SHALL discard the partial history; detection SHALL restart from an empty fill.

Verification
REQ-033 Bench: pat=0110, len=4, ovl=1, stream 0,1,1,0,1,1,0 -> out pulses after bits 4 and 7; match_cnt=2.
REQ-034 Bench: same stream with ovl=0 -> a single out pulse after bit 4; match_cnt=1.
REQ-035 Bench: len=4, pat=0110, bits 0,1 then in_valid=0 for 3 cycles, then 1,0 -> one pulse after the final bit, with no pulses during the gap.
REQ-036 Bench: pat_len=0, then pat_len=PAT_W+1, each followed by 20 random bits -> cfg_err=1, out never 1, match_cnt unchanged.
REQ-037 Bench: CNT_W=2, pat=1, len=1, 6 ones -> match_cnt saturates at 3; cnt_clr in the same cycle as a match -> match_cnt=0.
REQ-038 Bench: reset after bits 0,1,1 of 0110, then bit 0 -> no pulse; cfg_load coinciding with in_valid -> that bit is not counted in fill.
